// File: rtl/data_sync_pkg.sv
// data_sync_pkg: shared types and helpers for the enable-qualified CDC launcher
//   state_t      handshake FSM states
//   DEF_TIMEOUT  default per-phase wait limit
//   cnt_width()  bits needed to count 0..timeout
package data_sync_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        LAUNCH,
        RELEASE
    } state_t;

    localparam int DEF_TIMEOUT = 255;

    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/data_sync_tx_bit_sync.sv
// bit_sync: multi-flop synchronizer for a single level signal
//   i_clk  in   destination clock for the level
//   i_rst  in   synchronous active-high reset, clears the chain
//   i_d    in   asynchronous level
//   o_q    out  synchronized level (last stage)
module bit_sync #(
    parameter int NUM_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [NUM_STAGES-1:0] r_chain;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_chain <= '0;
        else
            r_chain <= {r_chain[NUM_STAGES-2:0], i_d};
    end

    assign o_q = r_chain[NUM_STAGES-1];

endmodule

// File: rtl/data_sync_tx.sv
// data_sync_tx: source-side launcher for an enable-qualified multi-bit CDC bus
//   CLK          in   source-domain clock
//   RST          in   synchronous active-high reset
//   in_valid     in   local word available
//   in_data      in   local word
//   in_ready     out  accepting a word (IDLE)
//   ack_async    in   destination's copy of bus_enable, asynchronous level
//   unsync_bus   out  registered word, stable while bus_enable is high
//   bus_enable   out  registered qualifier for unsync_bus
//   busy         out  handshake in progress
//   done_pulse   out  one-cycle pulse on normal completion
//   timeout_err  out  one-cycle pulse on a phase timeout
// Optional: define DATA_SYNC_TX_TIMEOUT_EN to bound each LAUNCH/RELEASE wait
// to TIMEOUT cycles; without it the FSM waits indefinitely and timeout_err is 0.
module data_sync_tx
    import data_sync_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int WIDTH      = 8,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             ack_async,
    output logic [WIDTH-1:0] unsync_bus,
    output logic             bus_enable,
    output logic             busy,
    output logic             done_pulse,
    output logic             timeout_err
);

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_bus, w_bus;
    logic             r_en, w_en;
    logic             r_done, w_done;
    logic             r_terr, w_terr;
    logic             w_ack_sync;
    logic             w_to;
    logic             w_aborted;

    bit_sync #(
        .NUM_STAGES(NUM_STAGES)
    ) u_ack_sync (
        .i_clk(CLK),
        .i_rst(RST),
        .i_d  (ack_async),
        .o_q  (w_ack_sync)
    );

`ifdef DATA_SYNC_TX_TIMEOUT_EN
    localparam int               CNT_W   = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_cnt;
    logic             r_aborted;

    // Counter restarts on every state change so each phase gets its own budget.
    always_ff @(posedge CLK) begin
        if (RST || w_next != r_state)
            r_cnt <= '0;
        else if ((r_state == LAUNCH || r_state == RELEASE) && r_cnt != CNT_MAX)
            r_cnt <= r_cnt + 1'b1;
    end

    // Remembers that LAUNCH gave up, so the later ack drop is not reported as done.
    always_ff @(posedge CLK) begin
        if (RST || r_state == IDLE)
            r_aborted <= 1'b0;
        else if (r_state == LAUNCH && w_terr)
            r_aborted <= 1'b1;
    end

    assign w_to      = (r_cnt == CNT_MAX);
    assign w_aborted = r_aborted;
`else
    assign w_to      = 1'b0;
    assign w_aborted = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        w_bus  = r_bus;
        w_en   = r_en;
        w_done = 1'b0;
        w_terr = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_bus  = in_data;
                    w_next = SETUP;
                end
            end
            SETUP: begin
                w_en   = 1'b1;
                w_next = LAUNCH;
            end
            LAUNCH: begin
                // A real ack wins over a timeout landing on the same cycle.
                if (w_ack_sync || w_to) begin
                    w_en   = 1'b0;
                    w_terr = !w_ack_sync;
                    w_next = RELEASE;
                end
            end
            RELEASE: begin
                if (!w_ack_sync) begin
                    w_done = !w_aborted;
                    w_next = IDLE;
                end else if (w_to) begin
                    w_terr = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_bus   <= '0;
            r_en    <= 1'b0;
            r_done  <= 1'b0;
            r_terr  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_bus   <= w_bus;
            r_en    <= w_en;
            r_done  <= w_done;
            r_terr  <= w_terr;
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign busy        = !in_ready;
    assign unsync_bus  = r_bus;
    assign bus_enable  = r_en;
    assign done_pulse  = r_done;
    assign timeout_err = r_terr;

endmodule

// File: tb/tb_data_sync_tx.sv
// tb_data_sync_tx: self-checking bench for data_sync_tx with an ack echo model
module tb_data_sync_tx;

    localparam int W  = 8;
    localparam int NS = 2;
    localparam int TO = 15;

    logic         CLK = 1'b0;
    logic         RST;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         ack_async;
    logic [W-1:0] unsync_bus;
    logic         bus_enable;
    logic         busy;
    logic         done_pulse;
    logic         timeout_err;

    data_sync_tx #(
        .NUM_STAGES(NS),
        .WIDTH     (W),
        .TIMEOUT   (TO)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .ack_async  (ack_async),
        .unsync_bus (unsync_bus),
        .bus_enable (bus_enable),
        .busy       (busy),
        .done_pulse (done_pulse),
        .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          failures = 0;
    int          done_cnt = 0;
    int          terr_cnt = 0;
    logic [15:0] en_hist = '0;
    int          ack_d = 1;
    bit          ack_force = 1'b1;
    logic        ack_val = 1'b0;

    typedef struct {
        logic [7:0] data;
        int         d;
        int         exp_done;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Destination model: ack_async after edge k is bus_enable seen after edge k-ack_d.
    task automatic tick();
        @(posedge CLK);
        #1;
        en_hist   = {en_hist[14:0], bus_enable};
        ack_async = ack_force ? ack_val : en_hist[ack_d];
        if (done_pulse) done_cnt++;
        if (timeout_err) terr_cnt++;
    endtask

    // One word with echo delay d; done is expected exp_done edges after the accept edge.
    task automatic run_word(input logic [7:0] data, input int d, input int exp_done, input string tag);
        int rise_k;
        int done_k;
        int d0;
        bit stable;
        ack_force = 1'b0;
        ack_d     = d;
        d0        = done_cnt;
        rise_k    = -1;
        done_k    = -1;
        stable    = 1'b1;
        in_valid  = 1'b1;
        in_data   = data;
        tick();
        chk($sformatf("%s_bus_t0", tag), unsync_bus, data);
        chk($sformatf("%s_busy_t0", tag), busy, 1);
        chk($sformatf("%s_ready_t0", tag), in_ready, 0);
        for (int k = 1; k <= 80 && done_k < 0; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            tick();
            if (bus_enable && rise_k < 0) rise_k = k;
            if (unsync_bus !== data) stable = 1'b0;
            if (done_pulse) begin
                done_k = k;
                chk($sformatf("%s_ready_at_done", tag), in_ready, 1);
                chk($sformatf("%s_en_at_done", tag), bus_enable, 0);
            end
        end
        in_valid = 1'b0;
        chk($sformatf("%s_en_rise_edge", tag), rise_k, 1);
        chk($sformatf("%s_done_edge", tag), done_k, exp_done);
        chk($sformatf("%s_bus_stable", tag), stable, 1);
        chk($sformatf("%s_done_count", tag), done_cnt - d0, 1);
        tick();
        chk($sformatf("%s_done_one_cycle", tag), done_pulse, 0);
        chk($sformatf("%s_idle_after", tag), in_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] words[3];
        int         d0;
        int         t0;
        int         j;
        int         acc_i;
        int         k_terr;
        int         k_fall;
        int         k_idle;
        int         k_done;
        bit         held;
        vecs[0] = '{8'hA5, 3, 13};
        vecs[1] = '{8'h00, 1, 9};
        vecs[2] = '{8'hFF, 5, 17};
        vecs[3] = '{8'h3C, 2, 11};
        words[0] = 8'h01;
        words[1] = 8'h02;
        words[2] = 8'h03;

        RST       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h99;
        ack_async = 1'b0;
        repeat (3) tick();
        chk("rst_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_en", bus_enable, 0);
        chk("rst_bus", unsync_bus, 0);
        chk("rst_done", done_pulse, 0);
        chk("rst_terr", timeout_err, 0);
        in_valid = 1'b0;
        RST      = 1'b0;
        repeat (2) tick();
        chk("idle_no_capture", unsync_bus, 0);

        foreach (vecs[i]) run_word(vecs[i].data, vecs[i].d, vecs[i].exp_done, $sformatf("vec%0d", i));

        // Back-to-back: in_valid held; each transaction is 13 edges plus one IDLE accept edge.
        ack_force = 1'b0;
        ack_d     = 3;
        d0        = done_cnt;
        j         = 0;
        acc_i     = 0;
        in_valid  = 1'b1;
        in_data   = words[0];
        for (int k = 0; k < 46; k++) begin
            tick();
            if (acc_i < 3 && k == acc_i * 14) begin
                chk($sformatf("b2b_capture%0d", acc_i), unsync_bus, words[acc_i]);
                acc_i++;
                if (acc_i < 3) in_data = words[acc_i];
                else in_valid = 1'b0;
            end
            if (done_pulse) begin
                chk($sformatf("b2b_done_edge%0d", j), k, 13 + 14 * j);
                j++;
            end
        end
        chk("b2b_done_total", done_cnt - d0, 3);
        chk("b2b_last_bus", unsync_bus, 8'h03);

        // Stale ack: ack_sync already high when LAUNCH is entered.
        ack_force = 1'b1;
        ack_val   = 1'b1;
        repeat (4) tick();
        d0       = done_cnt;
        in_valid = 1'b1;
        in_data  = 8'hC3;
        tick();
        in_valid = 1'b0;
        tick();
        chk("stale_en_high", bus_enable, 1);
        tick();
        chk("stale_en_dropped", bus_enable, 0);
        chk("stale_busy", busy, 1);
        ack_val = 1'b0;
        k_done  = -1;
        for (int k = 3; k <= 20 && k_done < 0; k++) begin
            tick();
            if (done_pulse) k_done = k;
        end
        chk("stale_done_edge", k_done, 6);
        chk("stale_done_count", done_cnt - d0, 1);

        // Destination never acks.
        ack_force = 1'b1;
        ack_val   = 1'b0;
        repeat (3) tick();
        d0       = done_cnt;
        t0       = terr_cnt;
        in_valid = 1'b1;
        in_data  = 8'h77;
        tick();
        in_valid = 1'b0;
`ifdef DATA_SYNC_TX_TIMEOUT_EN
        k_terr = -1;
        k_fall = -1;
        k_idle = -1;
        for (int k = 1; k <= 30 && k_idle < 0; k++) begin
            tick();
            if (timeout_err && k_terr < 0) k_terr = k;
            if (!bus_enable && k_fall < 0 && k > 1) k_fall = k;
            if (!busy && k_idle < 0) k_idle = k;
        end
        chk("to_launch_terr_edge", k_terr, 17);
        chk("to_launch_en_fall", k_fall, 17);
        chk("to_launch_idle_edge", k_idle, 18);
        chk("to_launch_no_done", done_cnt - d0, 0);
        chk("to_launch_terr_count", terr_cnt - t0, 1);
        // RELEASE timeout: ack stays high after enable drops.
        ack_val = 1'b1;
        repeat (4) tick();
        d0       = done_cnt;
        t0       = terr_cnt;
        in_valid = 1'b1;
        in_data  = 8'h4B;
        tick();
        in_valid = 1'b0;
        k_terr   = -1;
        k_idle   = -1;
        for (int k = 1; k <= 30 && k_idle < 0; k++) begin
            tick();
            if (timeout_err && k_terr < 0) k_terr = k;
            if (!busy && k_idle < 0) k_idle = k;
        end
        chk("to_release_terr_edge", k_terr, 18);
        chk("to_release_idle_edge", k_idle, 18);
        chk("to_release_no_done", done_cnt - d0, 0);
        chk("to_release_terr_count", terr_cnt - t0, 1);
        ack_val = 1'b0;
        repeat (4) tick();
`else
        held = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k > 1 && (!bus_enable || !busy)) held = 1'b0;
        end
        chk("wait_forever_held", held, 1);
        chk("wait_forever_no_terr", terr_cnt - t0, 0);
        chk("wait_forever_bus", unsync_bus, 8'h77);
        ack_force = 1'b0;
        ack_d     = 1;
        k_done    = -1;
        for (int k = 0; k < 30 && k_done < 0; k++) begin
            tick();
            if (done_pulse) k_done = k;
        end
        chk("wait_forever_done_seen", k_done >= 0, 1);
        chk("wait_forever_done_count", done_cnt - d0, 1);
`endif

        for (int n = 0; n < 20; n++) begin
            int d;
            ack_force = 1'b0;
            d         = $urandom_range(1, 6);
            in_valid  = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
            run_word(8'($urandom), d, 3 + 2 * d + 2 * NS, $sformatf("rnd%0d", n));
        end

        // Reset in the middle of LAUNCH drops the word silently.
        ack_force = 1'b1;
        ack_val   = 1'b0;
        repeat (2) tick();
        d0       = done_cnt;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("mid_rst_en_before", bus_enable, 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("mid_rst_en", bus_enable, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_bus", unsync_bus, 0);
        chk("mid_rst_done", done_pulse, 0);
        repeat (6) tick();
        chk("mid_rst_no_done", done_cnt - d0, 0);
        chk("mid_rst_stays_idle", busy, 0);

`ifdef DATA_SYNC_TX_TIMEOUT_EN
        chk("terr_total", terr_cnt, 2);
`else
        chk("terr_total", terr_cnt, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
